// File: rtl/iiitb_usr_pkg.sv
// iiitb_usr_pkg
//   Shared constants for the universal shift register: mode select
//   encodings and the default register width.
package iiitb_usr_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    SEL_SHL  = 2'b00,
    SEL_SHR  = 2'b01,
    SEL_LOAD = 2'b10,
    SEL_HOLD = 2'b11
  } sel_e;

endpackage : iiitb_usr_pkg

// File: rtl/usr_bit_mux.sv
// usr_bit_mux
//   Next-state selector for one bit of the universal shift register.
//   Ports:
//     sel_i   - mode select (shift left / shift right / load / hold)
//     cur_i   - current value of this bit
//     shl_i   - value entering this bit on a left shift
//     shr_i   - value entering this bit on a right shift
//     load_i  - parallel load value for this bit
//     nxt_o   - next value of this bit
module usr_bit_mux
  import iiitb_usr_pkg::*;
(
  input  logic [1:0] sel_i,
  input  logic       cur_i,
  input  logic       shl_i,
  input  logic       shr_i,
  input  logic       load_i,
  output logic       nxt_o
);

  // Anything not matching a defined encoding (including X/Z) falls to hold.
  always_comb begin
    nxt_o = cur_i;
    case (sel_i)
      SEL_SHL:  nxt_o = shl_i;
      SEL_SHR:  nxt_o = shr_i;
      SEL_LOAD: nxt_o = load_i;
      default:  nxt_o = cur_i;
    endcase
  end

endmodule : usr_bit_mux

// File: rtl/iiitb_usr.sv
// iiitb_usr
//   WIDTH-bit universal shift register: shift left, shift right,
//   parallel load or hold, selected every clock edge.
//   Ports:
//     data_in  - parallel load data
//     data_out - register contents, straight from the flops
//     clock    - rising-edge clock
//     clear    - asynchronous active-low reset (clears register)
//     select   - mode: 00 shl, 01 shr, 10 load, 11 hold
//     sl_ser   - serial bit entering LSB on a left shift
//     sr_ser   - serial bit entering MSB on a right shift
module iiitb_usr
  import iiitb_usr_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  input  logic             clock,
  input  logic             clear,
  input  logic [1:0]       select,
  input  logic             sl_ser,
  input  logic             sr_ser
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] shl_src;
  logic [WIDTH-1:0] shr_src;

  // Bit i receives shl_src[i] on a left shift and shr_src[i] on a right
  // shift; the bit pushed out of the far end is simply dropped.
  assign shl_src = {data_q[WIDTH-2:0], sl_ser};
  assign shr_src = {sr_ser, data_q[WIDTH-1:1]};

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    usr_bit_mux u_mux (
      .sel_i  (select),
      .cur_i  (data_q[i]),
      .shl_i  (shl_src[i]),
      .shr_i  (shr_src[i]),
      .load_i (data_in[i]),
      .nxt_o  (data_d[i])
    );
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_out = data_q;

endmodule : iiitb_usr

// File: tb/tb_iiitb_usr.sv
module tb_iiitb_usr;

  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       clock;
  logic       clear;
  logic [1:0] select;
  logic       sl_ser;
  logic       sr_ser;

  int n_chk  = 0;
  int n_pass = 0;

  iiitb_usr #(.WIDTH(8)) dut (
    .data_in  (data_in),
    .data_out (data_out),
    .clock    (clock),
    .clear    (clear),
    .select   (select),
    .sl_ser   (sl_ser),
    .sr_ser   (sr_ser)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%02h, want 0x%02h", tag, obs, exp);
  endtask

  // Advance one rising edge and sample just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] shr_exp [8] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
  logic [7:0] shl_exp [3] = '{8'hFE, 8'hFC, 8'hF8};

  initial begin
    data_in = 8'hAB;
    select  = 2'b10;
    sl_ser  = 1'b0;
    sr_ser  = 1'b0;
    clear   = 1'b0;
    #2;
    chk("reset_immediate", data_out, 8'h00);
    tick();
    chk("reset_over_load_e1", data_out, 8'h00);
    tick();
    chk("reset_over_load_e2", data_out, 8'h00);

    // Release and fill from the top with ones.
    clear  = 1'b1;
    select = 2'b01;
    sr_ser = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("shr_fill_%0d", i), data_out, shr_exp[i]);
    end
    tick();
    chk("shr_saturated", data_out, 8'hFF);

    select = 2'b00;
    sl_ser = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("shl_zero_%0d", i), data_out, shl_exp[i]);
    end
    sl_ser = 1'b1;
    tick();
    chk("shl_one", data_out, 8'hF1);

    select  = 2'b10;
    data_in = 8'hAB;
    tick();
    chk("load_ab", data_out, 8'hAB);

    select  = 2'b11;
    data_in = 8'hF0;
    sl_ser  = 1'b0;
    sr_ser  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("hold_%0d", i), data_out, 8'hAB);
      sl_ser = ~sl_ser;
      sr_ser = ~sr_ser;
    end

    // Asynchronous clear between edges, released with a load pending.
    #2;
    clear = 1'b0;
    #1;
    chk("async_clear", data_out, 8'h00);
    select  = 2'b10;
    data_in = 8'hF0;
    #1;
    clear = 1'b1;
    #1;
    chk("clear_release_no_edge", data_out, 8'h00);
    tick();
    chk("load_after_release", data_out, 8'hF0);

    // Input changes between edges must not reach data_out.
    select  = 2'b10;
    data_in = 8'h55;
    #1;
    chk("mid_cycle_load", data_out, 8'hF0);
    select = 2'b00;
    sl_ser = 1'b1;
    #1;
    chk("mid_cycle_shl", data_out, 8'hF0);
    select = 2'b01;
    sr_ser = 1'b0;
    tick();
    chk("edge_shr_zero", data_out, 8'h78);

    // Reset mid-shift leaves nothing behind.
    sr_ser = 1'b1;
    tick();
    chk("shr_one", data_out, 8'hBC);
    clear = 1'b0;
    #1;
    chk("abort_shift", data_out, 8'h00);
    clear = 1'b1;
    tick();
    chk("shift_after_abort", data_out, 8'h80);

    // Left shift discards MSB, no wrap.
    select  = 2'b10;
    data_in = 8'h81;
    tick();
    chk("load_81", data_out, 8'h81);
    select = 2'b00;
    sl_ser = 1'b0;
    tick();
    chk("shl_drop_msb", data_out, 8'h02);
    select = 2'b01;
    sr_ser = 1'b0;
    tick();
    chk("shr_back", data_out, 8'h01);
    tick();
    chk("shr_drop_lsb", data_out, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_iiitb_usr
